// File: rtl/alu_issue_queue.sv
// alu_issue_queue: command FIFO that feeds a combinational ALU, owns its state register and registers results.
// Optional macro OVF_HALT_EN: an issued result with overflow also halts issue.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [2:0]               inFunct,
    input  logic [WIDTH-1:0]         inA,
    input  logic [WIDTH-1:0]         inB,
    input  logic                     clrErr,
    output logic [2:0]               aluFunct,
    output logic [WIDTH-1:0]         aluA,
    output logic [WIDTH-1:0]         aluB,
    output logic [1:0]               aluCurrentState,
    input  logic [1:0]               aluNextState,
    input  logic [WIDTH-1:0]         aluOut,
    input  logic                     aluCarry,
    input  logic                     aluOverflow,
    output logic                     resValid,
    input  logic                     resReady,
    output logic [WIDTH-1:0]         resOut,
    output logic                     resCarry,
    output logic                     resOverflow,
    output logic [1:0]               resState,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {RUN, HALT} halt_t;

    logic [2:0]       funct_mem [DEPTH];
    logic [WIDTH-1:0] a_mem [DEPTH];
    logic [WIDTH-1:0] b_mem [DEPTH];
    logic [AW-1:0]    head_q, tail_q;
    logic [AW:0]      count_q, count_d;
    logic [1:0]       state_q;
    halt_t            fsm_q;
    logic             res_valid_q, res_carry_q, res_ovf_q;
    logic [WIDTH-1:0] res_out_q;
    logic [1:0]       res_state_q;
    logic             empty, full, push, issue, err_hit;

    assign empty   = count_q == '0;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign push    = inValid && !full;
    assign issue   = !empty && fsm_q == RUN && (!res_valid_q || resReady);
`ifdef OVF_HALT_EN
    assign err_hit = aluNextState == 2'd3 || aluOverflow;
`else
    assign err_hit = aluNextState == 2'd3;
`endif

    assign inReady         = !full;
    assign aluFunct        = empty ? '0 : funct_mem[head_q];
    assign aluA            = empty ? '0 : a_mem[head_q];
    assign aluB            = empty ? '0 : b_mem[head_q];
    assign aluCurrentState = state_q;
    assign resValid        = res_valid_q;
    assign resOut          = res_out_q;
    assign resCarry        = res_carry_q;
    assign resOverflow     = res_ovf_q;
    assign resState        = res_state_q;
    assign halted          = fsm_q == HALT;
    assign count           = count_q;

    // occupancy after this edge's push and pop
    always_comb begin
        count_d = count_q + (AW+1)'(push) - (AW+1)'(issue);
    end

    // command storage; contents are only meaningful between head and tail
    always_ff @(posedge clk) begin
        if (push) begin
            funct_mem[tail_q] <= inFunct;
            a_mem[tail_q]     <= inA;
            b_mem[tail_q]     <= inB;
        end
    end

    // FIFO pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) tail_q <= tail_q + 1'b1;
            if (issue) head_q <= head_q + 1'b1;
        end
    end

    // result register and ALU state register; an issue outranks clrErr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= '0;
            res_valid_q <= 1'b0;
            res_out_q   <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_state_q <= '0;
        end else if (issue) begin
            state_q     <= aluNextState;
            res_valid_q <= 1'b1;
            res_out_q   <= aluOut;
            res_carry_q <= aluCarry;
            res_ovf_q   <= aluOverflow;
            res_state_q <= aluNextState;
        end else begin
            if (resReady) res_valid_q <= 1'b0;
            if (clrErr) state_q <= '0;
        end
    end

    // halt FSM: stop issuing after an error result until clrErr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= RUN;
        end else begin
            case (fsm_q)
                RUN:     if (issue && err_hit) fsm_q <= HALT;
                HALT:    if (clrErr) fsm_q <= RUN;
                default: fsm_q <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: random and directed stimulus, queue-level reference model and result scoreboard.
module tb_alu_issue_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
`ifdef OVF_HALT_EN
    localparam bit OVF_HALT = 1'b1;
`else
    localparam bit OVF_HALT = 1'b0;
`endif

    typedef struct packed {logic [2:0] f; logic [7:0] a; logic [7:0] b;} cmd_t;
    typedef struct packed {logic [7:0] o; logic c; logic v; logic [1:0] s;} res_t;

    logic clk, reset, inValid, inReady, clrErr, aluCarry, aluOverflow;
    logic resValid, resReady, resCarry, resOverflow, halted;
    logic [2:0] inFunct, aluFunct;
    logic [7:0] inA, inB, aluA, aluB, aluOut, resOut;
    logic [1:0] aluCurrentState, aluNextState, resState;
    logic [2:0] count;

    int total = 0;
    int bad = 0;
    cmd_t mq[$];
    res_t exp_q[$];
    bit mrv, mh;
    logic [1:0] mstate;
    res_t mon_e;

    alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .inFunct(inFunct), .inA(inA), .inB(inB), .clrErr(clrErr),
        .aluFunct(aluFunct), .aluA(aluA), .aluB(aluB),
        .aluCurrentState(aluCurrentState), .aluNextState(aluNextState),
        .aluOut(aluOut), .aluCarry(aluCarry), .aluOverflow(aluOverflow),
        .resValid(resValid), .resReady(resReady), .resOut(resOut),
        .resCarry(resCarry), .resOverflow(resOverflow), .resState(resState),
        .halted(halted), .count(count)
    );

    // 8-bit ALU behaviour; A=5A,B=A5 forces the ERROR next state
    function automatic res_t alu_ref(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        res_t r;
        logic [8:0] w;
        r = '0;
        case (f)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r.v = (a[7] == b[7]) && (w[7] != a[7]); end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; r.v = (a[7] != b[7]) && (w[7] != a[7]); end
            3'd2: w = {a, 1'b0};
            3'd3: w = {a[0], 1'b0, a[7:1]};
            3'd4: w = {1'b0, a & b};
            3'd5: w = {1'b0, a | b};
            3'd6: w = {1'b0, a ^ b};
            default: w = {1'b0, ~a};
        endcase
        r.o = w[7:0];
        r.c = w[8];
        r.s = (a == 8'h5A && b == 8'hA5) ? 2'd3 : (r.o == 8'd0 ? 2'd2 : 2'd1);
        return r;
    endfunction

    assign {aluOut, aluCarry, aluOverflow, aluNextState} = alu_ref(aluFunct, aluA, aluB);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // one clock: drive inputs, predict the edge, then compare observable state
    task automatic cycle(input bit v, input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                         input bit rr, input bit ce);
        cmd_t c, h;
        res_t r;
        bit acc, iss;
        inValid = v; inFunct = f; inA = a; inB = b; resReady = rr; clrErr = ce;
        c = '{f, a, b};
        acc = v && mq.size() < DEPTH;
        iss = mq.size() != 0 && !mh && (!mrv || rr);
        @(posedge clk);
        #2;
        if (iss) begin
            h = mq.pop_front();
            r = alu_ref(h.f, h.a, h.b);
            mstate = r.s;
            mrv = 1'b1;
            if (r.s == 2'd3 || (OVF_HALT && r.v)) mh = 1'b1;
        end else begin
            if (mrv && rr) mrv = 1'b0;
            if (ce) begin mstate = 2'd0; mh = 1'b0; end
        end
        if (acc) begin
            mq.push_back(c);
            exp_q.push_back(alu_ref(f, a, b));
        end
        h = mq.size() != 0 ? mq[0] : '0;
        check("count", 32'(count), 32'(mq.size()));
        check("inReady", 32'(inReady), 32'(mq.size() < DEPTH));
        check("halted", 32'(halted), 32'(mh));
        check("resValid", 32'(resValid), 32'(mrv));
        check("aluCurrentState", 32'(aluCurrentState), 32'(mstate));
        check("head", 32'({aluFunct, aluA, aluB}), 32'(h));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, mh);
    endtask

    // scoreboard monitor: a result shown with resReady high is consumed at the next edge
    always @(negedge clk) begin
        if (!reset && resValid && resReady) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got result %0h expected none", resOut);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", 32'({resOut, resCarry, resOverflow, resState}), 32'(mon_e));
            end
        end
    end

    initial begin
        clk = 0; reset = 1; inValid = 0; inFunct = 0; inA = 0; inB = 0; resReady = 0; clrErr = 0;
        mrv = 0; mh = 0; mstate = 0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_inReady", 32'(inReady), 1);
        check("rst_resValid", 32'(resValid), 0);
        check("rst_res", 32'({resOut, resCarry, resOverflow, resState}), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_state", 32'(aluCurrentState), 0);
        reset = 0;
        // single ADD: two edges from acceptance to resValid
        cycle(1, 3'd0, 8'd24, 8'd6, 1, 0);
        check("lat_not_yet", 32'(resValid), 0);
        cycle(0, 3'd0, 8'd0, 8'd0, 1, 0);
        check("add_valid", 32'(resValid), 1);
        check("add_out", 32'({resOut, resCarry, resOverflow}), 32'({8'd30, 1'b0, 1'b0}));
        idle(2);
        // back-to-back SUB/AND/OR/XOR
        cycle(1, 3'd1, 8'd24, 8'd6, 1, 0);
        cycle(1, 3'd4, 8'd24, 8'd6, 1, 0);
        check("sub_out", 32'(resOut), 18);
        cycle(1, 3'd5, 8'd24, 8'd6, 1, 0);
        check("and_out", 32'(resOut), 0);
        cycle(1, 3'd6, 8'd24, 8'd6, 1, 0);
        check("or_out", 32'(resOut), 30);
        cycle(0, 3'd0, 8'd0, 8'd0, 1, 0);
        check("xor_out", 32'(resOut), 30);
        idle(2);
        // backpressure: fill the FIFO, extra pushes dropped
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, 3'(i), 8'(8 * i + 3), 8'(i + 1), 0, 0);
        check("full_count", 32'(count), DEPTH);
        check("full_inReady", 32'(inReady), 0);
        idle(DEPTH + 3);
        // error halt and clear
        cycle(1, 3'd0, 8'h5A, 8'hA5, 1, 0);
        cycle(1, 3'd5, 8'd1, 8'd2, 1, 0);
        cycle(1, 3'd6, 8'd3, 8'd4, 1, 0);
        check("err_state", 32'(resState), 3);
        cycle(0, 3'd0, 8'd0, 8'd0, 1, 0);
        cycle(0, 3'd0, 8'd0, 8'd0, 1, 0);
        check("halt_hold", 32'(count), 2);
        cycle(0, 3'd0, 8'd0, 8'd0, 1, 1);
        check("clr_state", 32'(aluCurrentState), 0);
        idle(4);
        // signed overflow
        cycle(1, 3'd0, 8'd100, 8'd100, 1, 0);
        cycle(1, 3'd1, 8'd1, 8'd1, 1, 0);
        check("ovf_out", 32'({resOut, resOverflow}), 32'({8'hC8, 1'b1}));
        check("ovf_halt", 32'(halted), 32'(OVF_HALT));
        idle(4);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 40) == 0) begin ra = 8'h5A; rb = 8'hA5; end
            cycle($urandom_range(0, 3) != 0, 3'($urandom), ra, rb, $urandom_range(0, 3) != 0,
                  mh ? $urandom_range(0, 3) == 0 : $urandom_range(0, 31) == 0);
        end
        idle(12);
        check("drained", 32'(exp_q.size()), 0);
        // asynchronous reset with queued commands and a held result
        if (mh) cycle(0, 3'd0, 8'd0, 8'd0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, 3'd0, 8'(i + 40), 8'd1, 0, 0);
        reset = 1;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_resValid", 32'(resValid), 0);
        check("arst_halted", 32'(halted), 0);
        check("arst_state", 32'(aluCurrentState), 0);
        check("arst_inReady", 32'(inReady), 1);
        inValid = 0;
        mq.delete(); exp_q.delete(); mrv = 0; mh = 0; mstate = 0;
        #1 reset = 0;
        cycle(1, 3'd2, 8'h81, 8'd0, 1, 0);
        cycle(1, 3'd3, 8'h81, 8'd0, 1, 0);
        idle(4);
        check("final_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
